// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM states, add-3 constants and a clog2 helper for the BCD converter
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD = 4'd3;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: one double-dabble digit correction, add 3 when the digit is 5 or more
module bcd_digit_adj import bcd_pkg::*; (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = d >= BCD_ADJ_THRESH ? d + BCD_ADJ_ADD : d;
endmodule

// File: rtl/binary_to_bcd_stream.sv
// binary_to_bcd_stream: serial double-dabble converter with valid/ready, overflow flag, optional out_blank (BCD_BLANK_EN)
module binary_to_bcd_stream import bcd_pkg::*; #(
  parameter int BIN_W = 12,
  parameter int DIGITS = 4,
  parameter int SKIP_SAME = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIN_W-1:0]    in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_bcd,
  output logic                out_ovf,
`ifdef BCD_BLANK_EN
  output logic [DIGITS-1:0]   out_blank,
`endif
  output logic                busy
);
  localparam int CW = clog2(BIN_W + 1);
  localparam int BW = 4 * DIGITS;
  state_t state, state_n;
  logic [BIN_W-1:0] bin, bin_n, last;
  logic [BW-1:0] bcd, adj, bcd_n;
  logic [CW-1:0] cnt;
  logic ovf, ovf_n, msb, last_vld, take, skip, last_shift;
  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bcd_digit_adj u_adj (.d(bcd[4*d+:4]), .q(adj[4*d+:4]));
  end
  assign {msb, bcd_n, bin_n} = {adj, bin, 1'b0};
  assign ovf_n = ovf | msb;
  assign take = in_valid && state == IDLE;
  assign skip = SKIP_SAME != 0 && last_vld && in_data == last;
  assign last_shift = cnt == CW'(BIN_W - 1);
  assign in_ready = state == IDLE;
  assign busy = state == SHIFT;
  assign out_valid = state == DONE;
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  // next state: accept, shift BIN_W times, hold result until out_ready
  always_comb begin
    state_n = state == IDLE  ? (take && !skip ? SHIFT : IDLE) :
              state == SHIFT ? (last_shift ? DONE : SHIFT) :
              (out_ready ? IDLE : DONE);
  end
  // datapath: load sample, shift-add-3 each cycle, latch result on the final shift
  always_ff @(posedge clk) begin
    if (rst) begin
      bin <= '0;
      bcd <= '0;
      ovf <= 1'b0;
      cnt <= '0;
      last <= '0;
      last_vld <= 1'b0;
      out_bcd <= '0;
      out_ovf <= 1'b0;
    end else if (take && !skip) begin
      bin <= in_data;
      bcd <= '0;
      ovf <= 1'b0;
      cnt <= '0;
      last <= in_data;
      last_vld <= 1'b1;
    end else if (state == SHIFT) begin
      bin <= bin_n;
      bcd <= bcd_n;
      ovf <= ovf_n;
      cnt <= cnt + CW'(1);
      if (last_shift) begin
        out_bcd <= bcd_n;
        out_ovf <= ovf_n;
      end
    end
  end
`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] blank_n;
  // leading-zero mask: a digit blanks when it and every higher digit are zero, ones never blanks
  always_comb begin
    logic z;
    z = 1'b1;
    blank_n = '0;
    for (int k = DIGITS - 1; k > 0; k--) begin
      z = z && bcd_n[4*k+:4] == 4'd0;
      blank_n[k] = z;
    end
  end
  // blank mask registered alongside out_bcd
  always_ff @(posedge clk)
    if (rst) out_blank <= '0;
    else if (state == SHIFT && last_shift) out_blank <= blank_n;
`endif
endmodule

// File: tb/tb_binary_to_bcd_stream.sv
// tb_binary_to_bcd_stream: random and directed checks of two converters (4 and 3 digits) against an arithmetic model
module tb_binary_to_bcd_stream;
  logic clk = 1'b0;
  logic rst, in_valid, out_ready;
  logic [11:0] in_data;
  logic a_in_ready, a_out_valid, a_out_ovf, a_busy;
  logic b_in_ready, b_out_valid, b_out_ovf, b_busy;
  logic [15:0] a_bcd;
  logic [11:0] b_bcd;
`ifdef BCD_BLANK_EN
  logic [3:0] a_blank;
  logic [2:0] b_blank;
`endif
  int vectors = 0, miscompares = 0;
  logic [11:0] last_val;
  bit last_vld;
  logic [15:0] ea;
  logic [11:0] eb;
  logic eoa, eob;

  binary_to_bcd_stream dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_bcd(a_bcd), .out_ovf(a_out_ovf),
`ifdef BCD_BLANK_EN
    .out_blank(a_blank),
`endif
    .busy(a_busy));

  binary_to_bcd_stream #(.BIN_W(12), .DIGITS(3), .SKIP_SAME(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_bcd(b_bcd), .out_ovf(b_out_ovf),
`ifdef BCD_BLANK_EN
    .out_blank(b_blank),
`endif
    .busy(b_busy));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] to_bcd(input int v, input int d);
    logic [39:0] r;
    r = '0;
    for (int k = 0; k < d; k++) begin
      r[4*k+:4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic ovf_of(input int v, input int d);
    int p;
    p = 1;
    for (int k = 0; k < d; k++) p = p * 10;
    return v >= p;
  endfunction

`ifdef BCD_BLANK_EN
  function automatic logic [9:0] blank_of(input int v, input int d);
    logic [39:0] r;
    logic [9:0] b;
    bit z;
    r = to_bcd(v, d);
    b = '0;
    z = 1'b1;
    for (int k = d - 1; k > 0; k--) begin
      z = z && r[4*k+:4] == 4'd0;
      b[k] = z;
    end
    return b;
  endfunction
`endif

  task automatic send(input logic [11:0] v, input int hold);
    bit skip, seen;
    int n;
    skip = last_vld && v == last_val;
    @(negedge clk);
    n = 0;
    while (!a_in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!a_in_ready) begin
      check("ready_timeout", 0, 1);
      return;
    end
    out_ready = hold == 0;
    in_valid = 1'b1;
    in_data = v;
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_data = 12'($urandom);
    if (skip) begin
      seen = 1'b0;
      repeat (16) begin
        @(negedge clk);
        seen = seen | a_out_valid | b_out_valid | a_busy;
      end
      check("skip_no_conv", seen, 0);
      check("skip_ready", a_in_ready, 1);
      check("skip_bcd_a", a_bcd, ea);
      check("skip_bcd_b", b_bcd, eb);
      check("skip_ovf_b", b_out_ovf, eob);
      return;
    end
    last_val = v;
    last_vld = 1'b1;
    ea = 16'(to_bcd(v, 4));
    eb = 12'(to_bcd(v, 3));
    eoa = ovf_of(v, 4);
    eob = ovf_of(v, 3);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) check("busy_state", {a_busy, a_in_ready}, 2'b10);
      seen = a_out_valid;
    end
    check("latency", n, 13);
    check("bcd_a", a_bcd, ea);
    check("ovf_a", a_out_ovf, eoa);
    check("bcd_b", b_bcd, eb);
    check("ovf_b", b_out_ovf, eob);
    check("valid_b", b_out_valid, 1);
    check("done_ready", a_in_ready, 0);
`ifdef BCD_BLANK_EN
    check("blank_a", a_blank, 4'(blank_of(v, 4)));
    check("blank_b", b_blank, 3'(blank_of(v, 3)));
`endif
    if (hold > 0) begin
      in_valid = 1'b1;
      in_data = v + 12'd1;
      repeat (hold) begin
        @(negedge clk);
        check("hold_valid", a_out_valid, 1);
        check("hold_bcd", a_bcd, ea);
        check("hold_ready", a_in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    check("valid_drop", a_out_valid, 0);
    check("back_idle", a_in_ready, 1);
    check("keep_bcd", a_bcd, ea);
  endtask

  task automatic reset_mid(input logic [11:0] v);
    bit seen;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = v;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_valid", a_out_valid, 0);
    check("rst_bcd", a_bcd, 0);
    check("rst_ovf", a_out_ovf, 0);
    check("rst_ready", a_in_ready, 1);
    check("rst_busy", a_busy, 0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | a_out_valid | b_out_valid;
    end
    check("rst_no_valid", seen, 0);
    last_vld = 1'b0;
    ea = '0;
    eb = '0;
    eoa = 1'b0;
    eob = 1'b0;
  endtask

  initial begin
    logic [11:0] v;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    last_vld = 1'b0;
    last_val = '0;
    ea = '0;
    eb = '0;
    eoa = 1'b0;
    eob = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", a_in_ready, 1);
    check("reset_valid", a_out_valid, 0);
    check("reset_bcd", a_bcd, 0);
    check("reset_ovf", a_out_ovf, 0);
    check("reset_busy", a_busy, 0);
`ifdef BCD_BLANK_EN
    check("reset_blank", a_blank, 0);
`endif
    rst = 1'b0;
    send(12'd4095, 0);
    send(12'd1000, 0);
    send(12'd999, 0);
    send(12'd1234, 5);
    send(12'd321, 0);
    send(12'd321, 0);
    send(12'd322, 0);
    reset_mid(12'd2048);
    send(12'd321, 0);
    send(12'd0, 0);
    send(12'd42, 0);
    send(12'd7, 0);
    for (int i = 0; i < 40; i++) begin
      v = (last_vld && $urandom_range(0, 3) == 0) ? last_val : 12'($urandom);
      send(v, int'($urandom_range(0, 3)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
